// File: rtl/sprite_pos_ctrl_if.sv
// Sprite position controller port bundle.
// Buttons and vsync in, sprite position and status out.
interface sprite_pos_ctrl_if;
    logic       iVS;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [9:0] oX;
    logic [8:0] oY;
    logic       oMoving;
    logic       oFrameTick;

    modport master (
        output iVS, up, down, left, right,
        input  oX, oY, oMoving, oFrameTick
    );

    modport slave (
        input  iVS, up, down, left, right,
        output oX, oY, oMoving, oFrameTick
    );
endinterface

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: debounced buttons move a sprite once per frame.
// Define SPRITE_WRAP_EN to wrap at screen edges instead of clamping.
module sprite_pos_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int STEP       = 2,
    parameter int X_MAX      = 640,
    parameter int Y_MAX      = 480,
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int X_INIT     = 304,
    parameter int Y_INIT     = 224
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    sprite_pos_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARMED, UPDATE, COMMIT} state_t;

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(DEB_CYCLES - 1);
    localparam logic signed [11:0] X_LIM  = 12'(X_MAX - SPR_W);
    localparam logic signed [11:0] Y_LIM  = 12'(Y_MAX - SPR_H);
    localparam logic signed [11:0] STEP_S = 12'(STEP);

    // bit 4 = vsync, bits 3..0 = up, down, left, right
    logic [4:0]         s1_q, s1_d, s2_q, s2_d;
    logic               vs_d1_q, vs_d1_d;
    logic               tick_q, tick_d;
    logic [3:0]         cand_q, cand_d;
    logic [3:0]         lvl_q, lvl_d;
    logic [CW-1:0]      cnt_q [4];
    logic [CW-1:0]      cnt_d [4];
    state_t             state_q, state_d;
    logic signed [11:0] dx_q, dx_d, dy_q, dy_d;
    logic [9:0]         x_q, x_d;
    logic [8:0]         y_q, y_d;

    logic [3:0]         press;
    logic               any_press;
    logic signed [11:0] nx, ny, nx_fit, ny_fit;

    function automatic logic signed [11:0] delta(input logic pos,
                                                 input logic neg);
        if (pos && !neg) return STEP_S;
        if (neg && !pos) return -STEP_S;
        return 12'sd0;
    endfunction

    function automatic logic signed [11:0] fit(input logic signed [11:0] v,
                                               input logic signed [11:0] lim);
`ifdef SPRITE_WRAP_EN
        if (v < 0)   return v + lim + 12'sd1;
        if (v > lim) return v - lim - 12'sd1;
        return v;
`else
        if (v < 0)   return 12'sd0;
        if (v > lim) return lim;
        return v;
`endif
    endfunction

    assign press     = ~lvl_q;
    assign any_press = |press;

    // Synchronizers and the registered frame-start pulse.
    always_comb begin
        s1_d    = {bus.iVS, bus.up, bus.down, bus.left, bus.right};
        s2_d    = s1_q;
        vs_d1_d = s2_q[4];
        tick_d  = vs_d1_q & ~s2_q[4];
    end

    // Per-button debounce: restart on change, accept after a stable run.
    always_comb begin
        cand_d = cand_q;
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (s2_q[i] != cand_q[i]) begin
                cand_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else if (cnt_q[i] == CNT_END) begin
                lvl_d[i] = cand_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Candidate next position from the delta latched in UPDATE.
    always_comb begin
        nx     = $signed({2'b00, x_q}) + dx_q;
        ny     = $signed({3'b000, y_q}) + dy_q;
        nx_fit = fit(nx, X_LIM);
        ny_fit = fit(ny, Y_LIM);
    end

    // Movement FSM: arm on a press, step once per frame tick.
    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (any_press) state_d = ARMED;
            end
            ARMED: begin
                if (tick_q)          state_d = UPDATE;
                else if (!any_press) state_d = IDLE;
            end
            UPDATE: begin
                dx_d    = delta(press[0], press[1]);
                dy_d    = delta(press[2], press[3]);
                state_d = COMMIT;
            end
            COMMIT: begin
                x_d     = nx_fit[9:0];
                y_d     = ny_fit[8:0];
                state_d = any_press ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizer and frame-tick registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            s1_q    <= '1;
            s2_q    <= '1;
            vs_d1_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            vs_d1_q <= vs_d1_d;
            tick_q  <= tick_d;
        end
    end

    // Debouncer registers, released level after reset.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cand_q <= '1;
            lvl_q  <= '1;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            cand_q <= cand_d;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
        end
    end

    // FSM state, latched delta and sprite position.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
            dx_q    <= '0;
            dy_q    <= '0;
            x_q     <= 10'(X_INIT);
            y_q     <= 9'(Y_INIT);
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign bus.oX         = x_q;
    assign bus.oY         = y_q;
    assign bus.oMoving    = (state_q != IDLE);
    assign bus.oFrameTick = tick_q;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Directed bench for sprite_pos_ctrl with a position scoreboard.
// Honours SPRITE_WRAP_EN for the edge expectations.
module tb_sprite_pos_ctrl;

    localparam int XL = 608;
    localparam int YL = 448;
    localparam int XI = 304;
    localparam int YI = 224;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ex, ey;
    int   sbx[$];
    int   sby[$];

    always #5 clk = ~clk;

    sprite_pos_ctrl_if bus();

    sprite_pos_ctrl #(
        .DEB_CYCLES(4),
        .STEP(2)
    ) dut (
        .iCLK(clk),
        .iRST_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mv(input int cur, input int d, input int lim);
        int n;
        n = cur + d;
`ifdef SPRITE_WRAP_EN
        if (n < 0) n = n + lim + 1;
        else if (n > lim) n = n - lim - 1;
`else
        if (n < 0) n = 0;
        else if (n > lim) n = lim;
`endif
        return n;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic btn(input bit u, input bit d, input bit l, input bit r);
        bus.up    = ~u;
        bus.down  = ~d;
        bus.left  = ~l;
        bus.right = ~r;
        idle(12);
    endtask

    task automatic wait_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.oFrameTick) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "/tick"}, 32'(seen), 32'd1);
    endtask

    // One frame: expected position pushed before the vsync edge,
    // popped three samples after the tick.
    task automatic frame(input string tag, input int dx, input int dy,
                         input bit moving);
        int ox, oy;
        ox = ex;
        oy = ey;
        if (moving) begin
            ex = mv(ex, dx, XL);
            ey = mv(ey, dy, YL);
        end
        sbx.push_back(ex);
        sby.push_back(ey);
        bus.iVS = 1'b0;
        wait_tick(tag);
        bus.iVS = 1'b1;
        @(negedge clk);
        chk({tag, "/tick1"}, 32'(bus.oFrameTick), 32'd0);
        chk({tag, "/mov"}, 32'(bus.oMoving), 32'(moving));
        chk({tag, "/xhold1"}, 32'(bus.oX), 32'(ox));
        @(negedge clk);
        chk({tag, "/xhold2"}, 32'(bus.oX), 32'(ox));
        chk({tag, "/yhold2"}, 32'(bus.oY), 32'(oy));
        @(negedge clk);
        chk({tag, "/x"}, 32'(bus.oX), 32'(sbx.pop_front()));
        chk({tag, "/y"}, 32'(bus.oY), 32'(sby.pop_front()));
        idle(4);
    endtask

    initial begin
        bit mov_seen;
        bus.iVS   = 1'b1;
        bus.up    = 1'b1;
        bus.down  = 1'b1;
        bus.left  = 1'b1;
        bus.right = 1'b1;
        idle(3);
        chk("rst_x", 32'(bus.oX), 32'd304);
        chk("rst_y", 32'(bus.oY), 32'd224);
        chk("rst_mov", 32'(bus.oMoving), 32'd0);
        chk("rst_tick", 32'(bus.oFrameTick), 32'd0);
        rst_n = 1'b1;
        ex = XI;
        ey = YI;

        // press lands together with a frame start: too early to move
        bus.right = 1'b0;
        frame("early", 2, 0, 1'b0);
        for (int f = 0; f < 3; f++) frame("right", 2, 0, 1'b1);
        chk("right_x", 32'(bus.oX), 32'd310);
        chk("right_y", 32'(bus.oY), 32'd224);
        btn(0, 0, 0, 0);
        chk("rel_mov", 32'(bus.oMoving), 32'd0);

        // glitch shorter than the debounce window
        bus.left = 1'b0;
        idle(2);
        bus.left = 1'b1;
        mov_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.oMoving) mov_seen = 1'b1;
        end
        chk("glitch_mov", 32'(mov_seen), 32'd0);
        frame("glitch_f", -2, 0, 1'b0);
        chk("glitch_x", 32'(bus.oX), 32'd310);

        rst_n = 1'b0;
        idle(2);
        chk("rst2_x", 32'(bus.oX), 32'd304);
        rst_n = 1'b1;
        ex = XI;
        ey = YI;

        // opposing vertical presses cancel
        btn(1, 1, 0, 1);
        frame("cancel", 2, 0, 1'b1);
        chk("cancel_x", 32'(bus.oX), 32'd306);
        chk("cancel_y", 32'(bus.oY), 32'd224);

        btn(0, 0, 1, 0);
        while (ex != 0) frame("walk_l", -2, 0, 1'b1);
        frame("edge_l", -2, 0, 1'b1);
`ifdef SPRITE_WRAP_EN
        chk("edge_l_x", 32'(bus.oX), 32'd607);
`else
        chk("edge_l_x", 32'(bus.oX), 32'd0);
`endif

        btn(0, 1, 0, 0);
        while (ey != YL) frame("walk_d", 0, 2, 1'b1);
        frame("edge_d", 0, 2, 1'b1);
`ifdef SPRITE_WRAP_EN
        chk("edge_d_y", 32'(bus.oY), 32'd1);
`else
        chk("edge_d_y", 32'(bus.oY), 32'd448);
`endif
        btn(0, 0, 0, 0);

        // reset in the UPDATE cycle drops the pending step
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        ex = XI;
        ey = YI;
        btn(0, 0, 0, 1);
        frame("pre_rst", 2, 0, 1'b1);
        bus.iVS = 1'b0;
        wait_tick("upd_rst");
        bus.iVS = 1'b1;
        @(negedge clk);
        chk("upd_mov", 32'(bus.oMoving), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("upd_rst_x", 32'(bus.oX), 32'd304);
        chk("upd_rst_mov", 32'(bus.oMoving), 32'd0);
        chk("upd_rst_tick", 32'(bus.oFrameTick), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_x", 32'(bus.oX), 32'd304);
        chk("post_rst_y", 32'(bus.oY), 32'd224);
        btn(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
